// File: rtl/muldiv_pkg.sv
// Shared encodings and width for the HI/LO multiply/divide unit.
// Op codes match the two-bit op port: op[1] selects divide, op[0] selects unsigned.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/sign_mag.sv
// Conditional two's-complement negator; purely combinational, zero latency.
// Used for operand magnitudes on the way in and for sign fix-up on the way out.
module sign_mag #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide: WIDTH-cycle shift-add / restoring divide, busy stalls MFHI/MFLO, done pulses on writeback.
// Build option MULDIV_FAST_MULT_EN: MULT/MULTU finish the cycle after start with a combinational multiply, busy stays low.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  // acc: running product high word / partial remainder; sh: multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d;
  logic [WIDTH-1:0]   b_q, b_d, a_raw_q, a_raw_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               b_zero_q, b_zero_d;
`ifdef MULDIV_FAST_MULT_EN
  logic               fast_q, fast_d;
`endif

  logic               is_signed, start_ok;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx, rem_nx, quot_nx;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  sign_mag #(.W(WIDTH)) u_mag_a (.neg(is_signed & A[WIDTH-1]), .din(A), .dout(a_mag));
  sign_mag #(.W(WIDTH)) u_mag_b (.neg(is_signed & B[WIDTH-1]), .din(B), .dout(b_mag));

  // One LSB-first shift-add step; the carry out of the add becomes the new top bit.
  assign mul_sum   = sh_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], sh_q[WIDTH-1:1]};

  // One restoring-divide step: bring in the next dividend bit, subtract if it fits.
  assign div_sh   = {acc_q, sh_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign rem_nx   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quot_nx  = {sh_q[WIDTH-2:0], div_ge};

`ifdef MULDIV_FAST_MULT_EN
  assign prod_raw = {{WIDTH{1'b0}}, sh_q} * {{WIDTH{1'b0}}, b_q};
  assign start_ok = start && (state_q == ST_IDLE) && !fast_q;
`else
  assign prod_raw = {mul_hi_nx, mul_lo_nx};
  assign start_ok = start && (state_q == ST_IDLE);
`endif

  sign_mag #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res_q), .din(prod_raw), .dout(prod_fix));
  sign_mag #(.W(WIDTH))   u_fix_quot (.neg(neg_res_q), .din(quot_nx),  .dout(quot_fix));
  sign_mag #(.W(WIDTH))   u_fix_rem  (.neg(neg_rem_q), .din(rem_nx),   .dout(rem_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    sh_d      = sh_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
`ifdef MULDIV_FAST_MULT_EN
    fast_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
`ifdef MULDIV_FAST_MULT_EN
        if (fast_q) begin
          hi_d   = prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = prod_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
`endif
        if (start_ok) begin
          acc_d     = '0;
          sh_d      = a_mag;
          b_d       = b_mag;
          a_raw_d   = A;
          neg_res_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = is_signed & A[WIDTH-1];
          b_zero_d  = (B == '0);
          cnt_d     = '0;
          if (op[1]) begin
            state_d = ST_DIV;
          end else begin
`ifdef MULDIV_FAST_MULT_EN
            fast_d  = 1'b1;
`else
            state_d = ST_MUL;
`endif
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_hi_nx;
        sh_d  = mul_lo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = prod_fix[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = rem_nx;
        sh_d  = quot_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          // Divide by zero reports the raw dividend, not the sign-fixed magnitude.
          if (b_zero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      sh_q      <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
`ifdef MULDIV_FAST_MULT_EN
      fast_q    <= fast_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {hi,lo} pushed at launch, popped at done.
// Latency expectations follow the MULDIV_FAST_MULT_EN build option.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = W;
  localparam int MUL_BUSY = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0, B = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [31:0] q, r;
    case (o)
      2'b00: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Drive one start pulse (edge 0), then scramble operands to prove they were registered.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  // Bounded wait for done; reports cycles since edge 0 and how many of them showed busy.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multu;
    int cyc, bn;
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (cyc != MUL_LAT) begin miscompares++; $display("FAIL multu_latency: got %0d want %0d", cyc, MUL_LAT); end
    vectors++; if (bn != MUL_BUSY) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d want %0d", bn, MUL_BUSY); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL multu_result: got %h want %h", {hi, lo}, e); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult;
    int cyc, bn;
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (cyc != MUL_LAT) begin miscompares++; $display("FAIL mult_latency: got %0d want %0d", cyc, MUL_LAT); end
    vectors++; if (bn != MUL_BUSY) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d want %0d", bn, MUL_BUSY); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL mult_result: got %h want %h", {hi, lo}, e); end
    tick();
  endtask

  task automatic test_div;
    int cyc, bn;
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (cyc != W) begin miscompares++; $display("FAIL div_latency: got %0d want %0d", cyc, W); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL div_signed: got %h want %h", {hi, lo}, e); end
    tick();
    exp_q.push_back({32'd100, 32'hFFFF_FFFF});
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (bn != W) begin miscompares++; $display("FAIL divu_zero_busy: got %0d want %0d", bn, W); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL divu_by_zero: got %h want %h", {hi, lo}, e); end
    tick();
  endtask

  task automatic test_overflow_ignore_start;
    int cyc, bn;
    logic [63:0] e;
    exp_q.push_back({32'h0, 32'h8000_0000});
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) tick();
    op = OP_MULTU; A = 32'd5; B = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (cyc + 10 != W) begin miscompares++; $display("FAIL ovf_latency: got %0d want %0d", cyc + 10, W); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL div_overflow: got %h want %h", {hi, lo}, e); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignored_start_queued: busy got %b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo;
    int cyc, bn;
    logic [63:0] e;
    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    vectors++; if (hi !== 32'h0000_1234) begin miscompares++; $display("FAIL mthi_idle: got %h want 00001234", hi); end
    lo_we = 1'b1; wdata = 32'h0000_5678;
    tick();
    lo_we = 1'b0;
    vectors++; if (lo !== 32'h0000_5678) begin miscompares++; $display("FAIL mtlo_idle: got %h want 00005678", lo); end
    exp_q.push_back({32'd2, 32'd14});
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (3) tick();
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    tick();
    vectors++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin miscompares++; $display("FAIL busy_strobe_or_stability: got %h want 0000123400005678", {hi, lo}); end
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL divu_after_mtlo: got %h want %h", {hi, lo}, e); end
    tick();
    // Strobe coincident with start lands immediately, then the result overwrites it.
    exp_q.push_back({32'd0, 32'd3});
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    launch(OP_DIVU, 32'd9, 32'd3);
    hi_we = 1'b0;
    vectors++; if (hi !== 32'h0000_ABCD) begin miscompares++; $display("FAIL strobe_with_start: got %h want 0000abcd", hi); end
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL result_over_strobe: got %h want %h", {hi, lo}, e); end
    tick();
  endtask

  task automatic test_abort;
    int cyc, bn, pulses;
    logic [63:0] e;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got busy,done=%b want 00", {busy, done}); end
    vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL abort_hilo: got %h want 0", {hi, lo}); end
    pulses = 0;
    repeat (40) begin
      tick();
      if (done) pulses++;
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL abort_late_done: got %0d pulses want 0", pulses); end
    exp_q.push_back({32'd0, 32'd42});
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(cyc, bn);
    e = exp_q.pop_front();
    vectors++; if (cyc != MUL_LAT) begin miscompares++; $display("FAIL after_abort_latency: got %0d want %0d", cyc, MUL_LAT); end
    vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL after_abort_result: got %h want %h", {hi, lo}, e); end
  endtask

  task automatic test_back_to_back;
    int cyc, bn, lat;
    logic [1:0] o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i);
      a = (i == 5) ? 32'h8000_0000 : $urandom;
      b = (i == 6 || i == 7) ? 32'h0 : ((i == 2) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (i == 2) a = 32'h8000_0001;
      exp_q.push_back(model(o, a, b));
      lat = o[1] ? W : MUL_LAT;
      // Launch lands in the done cycle of the previous operation.
      launch(o, a, b);
      wait_done(cyc, bn);
      e = exp_q.pop_front();
      vectors++; if (cyc != lat) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, lat); end
      vectors++; if ({hi, lo} !== e) begin miscompares++; $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {hi, lo}, e); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_overflow_ignore_start();
    test_mthi_mtlo();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
